// File: rtl/multi_port_flop_array.sv
// Small register-file style flop array: one write port, invalidate/flush control,
// RD_PORTS independent registered read ports and a registered valid-entry count.
module multi_port_flop_array #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_N   = 8,
    parameter int RD_PORTS = 2,
    parameter int BYPASS   = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           inv_en,
    input  logic [ADDR_W-1:0]              inv_addr,
    input  logic                           flush,
    input  logic [RD_PORTS-1:0]            rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0]     rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]     rd_data,
    output logic [RD_PORTS-1:0]            rd_vld,
    output logic [RD_PORTS-1:0]            rd_err,
    output logic                           wr_err,
    output logic [$clog2(DATA_N+1)-1:0]    count
);

    localparam int CNT_W = $clog2(DATA_N+1);

    logic [DATA_W-1:0]          data_q [DATA_N];
    logic [DATA_W-1:0]          data_d [DATA_N];
    logic [DATA_N-1:0]          valid_q;
    logic [DATA_N-1:0]          valid_d;
    logic [RD_PORTS*DATA_W-1:0] rd_data_d;
    logic [RD_PORTS-1:0]        rd_vld_d;
    logic [RD_PORTS-1:0]        rd_err_d;
    logic                       wr_err_d;
    logic [CNT_W-1:0]           count_d;

    // Invalidate is applied first so a same-address write overrides it; flush wins over both.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        wr_err_d = wr_en && (int'(wr_addr) >= DATA_N);
        for (int i = 0; i < DATA_N; i++) begin
            if (inv_en && (inv_addr == ADDR_W'(i))) begin
                valid_d[i] = 1'b0;
            end
            if (wr_en && !flush && (wr_addr == ADDR_W'(i))) begin
                valid_d[i] = 1'b1;
                data_d[i]  = wr_data;
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_comb begin
        rd_data_d = '0;
        rd_vld_d  = '0;
        rd_err_d  = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            if (rd_en[p]) begin
                rd_err_d[p] = 1'b1;
                for (int i = 0; i < DATA_N; i++) begin
                    if ((rd_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) &&
                        ((BYPASS != 0) ? valid_d[i] : valid_q[i])) begin
                        rd_vld_d[p]                  = 1'b1;
                        rd_err_d[p]                  = 1'b0;
                        rd_data_d[p*DATA_W +: DATA_W] = (BYPASS != 0) ? data_d[i] : data_q[i];
                    end
                end
            end
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < DATA_N; i++) begin
            if (valid_d[i]) begin
                count_d = count_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            rd_data <= '0;
            rd_vld  <= '0;
            rd_err  <= '0;
            wr_err  <= 1'b0;
            count   <= '0;
        end else begin
            valid_q <= valid_d;
            rd_data <= rd_data_d;
            rd_vld  <= rd_vld_d;
            rd_err  <= rd_err_d;
            wr_err  <= wr_err_d;
            count   <= count_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule
